// File: rtl/load_store_unit_if.sv
// Data-bus signal bundle between the load/store unit (master) and data memory (slave).
interface load_store_unit_if;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [3:0]  BusByteEn;
    logic [31:0] BusWData;
    logic [31:0] BusRData;
    logic        BusAck;

    modport master (
        output BusReq,
        output BusWe,
        output BusAddr,
        output BusByteEn,
        output BusWData,
        input  BusRData,
        input  BusAck
    );

    modport slave (
        input  BusReq,
        input  BusWe,
        input  BusAddr,
        input  BusByteEn,
        input  BusWData,
        output BusRData,
        output BusAck
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access unit: one req/ack bus transaction per load/store,
// core stall while busy, registered zero-extended load result, misalign and timeout faults.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      ByteAccess,
    input  logic [31:0]               Address,
    input  logic [31:0]               WriteData,
    output logic [31:0]               ReadData,
    output logic                      Stall,
    output logic                      BusFault,
    load_store_unit_if.master         bus
);

    typedef enum logic [1:0] {StIdle, StReq, StDone, StFault} state_e;

    localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  lane_q;
    logic        byte_q;
    logic [31:0] load_data;
    logic        access;

    assign access = MemRead | MemWrite;

    // Lane select uses the captured offset, since Address may move on while stalled.
    always_comb begin
        load_data = bus.BusRData;
        if (byte_q) begin
            unique case (lane_q)
                2'd0: load_data = {24'h0, bus.BusRData[7:0]};
                2'd1: load_data = {24'h0, bus.BusRData[15:8]};
                2'd2: load_data = {24'h0, bus.BusRData[23:16]};
                2'd3: load_data = {24'h0, bus.BusRData[31:24]};
                default: load_data = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            lane_q  <= 2'd0;
            byte_q  <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (access) begin
                        if (!ByteAccess && (Address[1:0] != 2'b00)) begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                            rdata_q <= 32'h0;
                        end else begin
                            addr_q  <= {Address[31:2], 2'b00};
                            we_q    <= MemWrite;
                            be_q    <= ByteAccess ? (4'b0001 << Address[1:0]) : 4'hF;
                            wdata_q <= ByteAccess ? {4{WriteData[7:0]}} : WriteData;
                            lane_q  <= Address[1:0];
                            byte_q  <= ByteAccess;
                            req_q   <= 1'b1;
                            cnt_q   <= 8'h0;
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    // An ack on the expiry cycle still completes the transaction.
                    if (bus.BusAck) begin
                        req_q   <= 1'b0;
                        state_q <= StDone;
                        if (!we_q) begin
                            rdata_q <= load_data;
                        end
                    end else if (cnt_q == CntMax) begin
                        req_q   <= 1'b0;
                        state_q <= StFault;
                        fault_q <= 1'b1;
                        rdata_q <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone:  state_q <= StIdle;
                StFault: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Stall         = ((state_q == StIdle) && access) || (state_q == StReq);
    assign ReadData      = rdata_q;
    assign BusFault      = fault_q;
    assign bus.BusReq    = req_q;
    assign bus.BusWe     = we_q;
    assign bus.BusAddr   = addr_q;
    assign bus.BusByteEn = be_q;
    assign bus.BusWData  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit (TIMEOUT=4) plus reset/ack corner sequences.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic        ByteAccess;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        BusFault;

    int n_cmp;
    int n_bad;

    load_store_unit_if bus_if ();

    load_store_unit #(
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ByteAccess (ByteAccess),
        .Address    (Address),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .Stall      (Stall),
        .BusFault   (BusFault),
        .bus        (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        bt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack;        // REQ cycle carrying the ack, 0 = never
        int          exp_req;    // expected REQ cycles
        logic        exp_fault;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_baddr;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];
    vec_t rst_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE, ends at the negedge of the IDLE cycle after DONE/FAULT.
    task automatic run_txn(input vec_t v, input int idx);
        int cyc;
        bit done;
        MemRead    = v.rd;
        MemWrite   = v.wr;
        ByteAccess = v.bt;
        Address    = v.addr;
        WriteData  = v.wdata;
        #1;
        check($sformatf("v%0d idle_stall", idx), 32'(Stall), 32'd1);
        check($sformatf("v%0d idle_req", idx), 32'(bus_if.BusReq), 32'd0);
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!bus_if.BusReq) begin
                done = 1'b1;
            end else if (cyc >= 12) begin
                check($sformatf("v%0d req_bound", idx), 32'(cyc), 32'(v.exp_req));
                done = 1'b1;
            end else begin
                cyc++;
                check($sformatf("v%0d req_stall", idx), 32'(Stall), 32'd1);
                if (cyc == 1) begin
                    check($sformatf("v%0d busaddr", idx), bus_if.BusAddr, v.exp_baddr);
                    check($sformatf("v%0d byteen", idx), 32'(bus_if.BusByteEn), 32'(v.exp_be));
                    check($sformatf("v%0d buswdata", idx), bus_if.BusWData, v.exp_bwdata);
                    check($sformatf("v%0d buswe", idx), 32'(bus_if.BusWe), 32'(v.exp_we));
                end
                bus_if.BusAck   = (cyc == v.ack);
                bus_if.BusRData = v.rdata;
                @(posedge clk);
                #1;
                bus_if.BusAck = 1'b0;
            end
        end
        check($sformatf("v%0d req_cycles", idx), 32'(cyc), 32'(v.exp_req));
        check($sformatf("v%0d end_fault", idx), 32'(BusFault), 32'(v.exp_fault));
        check($sformatf("v%0d end_stall", idx), 32'(Stall), 32'd0);
        check($sformatf("v%0d readdata", idx), ReadData, v.exp_rdata);
        @(negedge clk);
        check($sformatf("v%0d idle_fault", idx), 32'(BusFault), 32'd0);
        check($sformatf("v%0d idle_stall2", idx), 32'(Stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //           rd wr bt addr        wdata         rdata         ack req flt we be    baddr       bwdata        rdata
        vecs[0]  = '{1, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 1, 1, 0, 0, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1, 0, 1, 32'h103, 32'h0,        32'hAABBCCDD, 3, 3, 0, 0, 4'h8, 32'h100, 32'h0,        32'h000000AA};
        vecs[2]  = '{0, 1, 1, 32'h201, 32'h12345677, 32'h0,        1, 1, 0, 1, 4'h2, 32'h200, 32'h77777777, 32'h000000AA};
        vecs[3]  = '{1, 0, 0, 32'h102, 32'h0,        32'h0,        1, 0, 1, 0, 4'h0, 32'h0,   32'h0,        32'h0};
        vecs[4]  = '{0, 1, 0, 32'h300, 32'hCAFEF00D, 32'h0,        2, 2, 0, 1, 4'hF, 32'h300, 32'hCAFEF00D, 32'h0};
        vecs[5]  = '{1, 0, 1, 32'h301, 32'h0,        32'h11223344, 1, 1, 0, 0, 4'h2, 32'h300, 32'h0,        32'h00000033};
        vecs[6]  = '{1, 0, 0, 32'h400, 32'h0,        32'h0BADF00D, 0, 4, 1, 0, 4'hF, 32'h400, 32'h0,        32'h0};
        vecs[7]  = '{1, 0, 1, 32'h402, 32'h0,        32'h55667788, 4, 4, 0, 0, 4'h4, 32'h400, 32'h0,        32'h00000066};
        vecs[8]  = '{0, 1, 0, 32'h503, 32'h1,        32'h0,        1, 0, 1, 0, 4'h0, 32'h0,   32'h0,        32'h0};
        vecs[9]  = '{1, 0, 1, 32'h500, 32'h0,        32'h9ABCDEF0, 2, 2, 0, 0, 4'h1, 32'h500, 32'h0,        32'h000000F0};
        vecs[10] = '{1, 1, 0, 32'h600, 32'h01020304, 32'hFFFFFFFF, 1, 1, 0, 1, 4'hF, 32'h600, 32'h01020304, 32'h000000F0};
        rst_vec  = '{1, 0, 0, 32'h104, 32'h0,        32'h13579BDF, 1, 1, 0, 0, 4'hF, 32'h104, 32'h0,        32'h13579BDF};

        reset           = 1'b1;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        ByteAccess      = 1'b0;
        Address         = 32'h0;
        WriteData       = 32'h0;
        bus_if.BusAck   = 1'b0;
        bus_if.BusRData = 32'h0;
        #2;
        check("rst readdata", ReadData, 32'h0);
        check("rst busreq", 32'(bus_if.BusReq), 32'd0);
        check("rst buswe", 32'(bus_if.BusWe), 32'd0);
        check("rst busaddr", bus_if.BusAddr, 32'h0);
        check("rst byteen", 32'(bus_if.BusByteEn), 32'h0);
        check("rst buswdata", bus_if.BusWData, 32'h0);
        check("rst fault", 32'(BusFault), 32'd0);
        check("rst stall", 32'(Stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i], i);
        end

        // Ack while idle must not disturb anything.
        bus_if.BusAck   = 1'b1;
        bus_if.BusRData = 32'h12345678;
        repeat (3) @(negedge clk);
        check("idle_ack busreq", 32'(bus_if.BusReq), 32'd0);
        check("idle_ack stall", 32'(Stall), 32'd0);
        check("idle_ack readdata", ReadData, 32'h000000F0);
        check("idle_ack fault", 32'(BusFault), 32'd0);
        bus_if.BusAck = 1'b0;

        // Reset asserted mid-REQ.
        MemRead    = 1'b1;
        ByteAccess = 1'b0;
        Address    = 32'h700;
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        @(negedge clk);
        check("mid busreq_c1", 32'(bus_if.BusReq), 32'd1);
        @(posedge clk);
        #2;
        check("mid busreq_c2", 32'(bus_if.BusReq), 32'd1);
        reset = 1'b1;
        #1;
        check("mid busreq", 32'(bus_if.BusReq), 32'd0);
        check("mid readdata", ReadData, 32'h0);
        check("mid busaddr", bus_if.BusAddr, 32'h0);
        check("mid byteen", 32'(bus_if.BusByteEn), 32'h0);
        check("mid buswdata", bus_if.BusWData, 32'h0);
        check("mid buswe", 32'(bus_if.BusWe), 32'd0);
        check("mid fault", 32'(BusFault), 32'd0);
        check("mid stall", 32'(Stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst fault", 32'(BusFault), 32'd0);
            check("post_rst busreq", 32'(bus_if.BusReq), 32'd0);
        end
        run_txn(rst_vec, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
